// File: rtl/logic16_arbiter_if.sv
// Request/response bundle between two requesters and the shared 16-bit logic-unit arbiter.
// master = requester side, slave = arbiter side; rsp data is zero unless rsp valid is high.
interface logic16_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [1:0]       req0_op;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp0_ready;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       req1_op;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_data;
  logic             rsp1_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/logic16_arbiter.sv
// Round-robin share of one AND/OR/XOR/NOT unit; accept at T, response from T+2, one op per 3 cycles.
// Response is held until the owner's rsp_ready; no request is accepted outside IDLE.
module logic16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  logic16_arbiter_if.slave     bus,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
  } op_t;

  state_t           state;
  op_t              lat;
  logic             owner;
  logic             last_grant;
  logic [WIDTH-1:0] result;
  logic             rsp0_vld_q;
  logic             rsp1_vld_q;
  logic             gnt0;
  logic             gnt1;

  function automatic logic [WIDTH-1:0] logic_unit(input op_t x);
    logic [WIDTH-1:0] r;
    case (x.op)
      2'b00:   r = x.a & x.b;
      2'b01:   r = x.a | x.b;
      2'b10:   r = x.a ^ x.b;
      default: r = ~x.a;
    endcase
    return r;
  endfunction

  // Grant depends only on request valids and the fairness pointer, never on rsp_ready.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant)) gnt0 = 1'b1;
      else if (bus.req1_valid)                                gnt1 = 1'b1;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = rsp0_vld_q;
  assign bus.rsp1_valid = rsp1_vld_q;
  assign bus.rsp0_data  = rsp0_vld_q ? result : '0;
  assign bus.rsp1_data  = rsp1_vld_q ? result : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      result     <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            lat        <= gnt1 ? op_t'{bus.req1_a, bus.req1_b, bus.req1_op}
                               : op_t'{bus.req0_a, bus.req0_b, bus.req0_op};
            owner      <= gnt1;
            last_grant <= gnt1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result     <= logic_unit(lat);
          rsp0_vld_q <= !owner;
          rsp1_vld_q <= owner;
          state      <= RESP;
        end
        RESP: begin
          if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/logic16_arbiter.md
Name: logic16_arbiter

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters: requester 0 is the CPU-side microsequencer, requester 1 is the screen/blit DMA engine.
- Round-robin arbitration, operand latching, one-cycle execute, and a held response with a ready/valid handshake per requester.
- Sits between the requesters and the shared gate-level logic datapath. That datapath is the only place the bitwise functions are computed.

Parameters:
- WIDTH, 16, operand/result width in bits. Only 16 is supported by the datapath; other values are out of scope.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_op  input  2  requester 0 opcode
- rsp0_valid  output  1  result for requester 0 available
- rsp0_data  output  WIDTH  result for requester 0
- rsp0_ready  input  1  requester 0 consumes result
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp1_valid, rsp1_data, rsp1_ready  same as requester 0, for requester 1
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.

- Opcodes:
  - 00 = A AND B
  - 01 = A OR B
  - 10 = A XOR B
  - 11 = NOT A (B ignored)
  - Result is bitwise, full WIDTH; no flags.

- FSM states: IDLE, EXEC, RESP.
  - IDLE: if any reqN_valid, select a winner, assert reqN_ready for that requester only (combinational, same cycle), latch a/b/op and owner, then go to EXEC. If no request, stay in IDLE.
  - EXEC: present the latched operands to the logic unit and register the result into the result register. Go to RESP.
  - RESP: assert rspN_valid for the owner only. rspN_data = result register. rsp data for the non-owner = 0.
    - Stay in RESP while rspN_ready = 0; data held stable.
    - When rspN_ready = 1, go to IDLE next cycle.

- Handshakes:
  - reqN_ready is high only in IDLE, and only for the granted requester.
  - Requests are never accepted in EXEC/RESP.
  - Requesters hold valid/operands stable until ready.
  - Operand changes after acceptance have no effect.

- Arbitration:
  - Only one valid: it wins.
  - Both valid: the requester not granted last wins.
  - last_grant pointer updates on every acceptance.

- Latency and throughput:
  - Accept in cycle T → rsp_valid first high in cycle T+2.
  - With rsp_ready tied high, the next acceptance is at the earliest T+3, giving 1 op per 3 cycles.

- Reset values:
  - State = IDLE
  - last_grant = 1, so requester 0 wins the first tie
  - Result register = 0
  - All reqN_ready = 0 except the IDLE combinational grant
  - rspN_valid = 0, rspN_data = 0, busy = 0

- Reset mid-operation: the in-flight op is discarded with no response; the next cycle starts in IDLE.
- The ready/valid combinational path is only valid→ready; ready never depends on rsp_ready.

Test Plan:
- Single op: after reset, req0 a=16'hF0F0, b=16'h3C3C, op=00 → req0_ready same cycle, rsp0_valid at T+2, data 16'h3030; req1/rsp1 remain 0.
- All opcodes on requester 1: a=16'hAAAA, b=16'h0FF0 with op 01/10/11 → 16'hAFFA, 16'hA55A, 16'h5555.
- Tie fairness: both valid continuously with rsp_ready=1 → grants alternate 0,1,0,1; first grant goes to 0; one accept every 3 cycles.
- Backpressure: rsp0_ready=0 for 5 cycles → rsp0_valid and data held stable, busy=1, req1_valid ignored (req1_ready=0); release → IDLE next cycle, then req1 is granted.
- Reset mid-op: assert reset in EXEC → next cycle state IDLE, rsp0_valid never asserts, busy=0, last_grant=1.
- Operand stability: change req0_a in the cycle after acceptance → result reflects the latched value.
